// File: rtl/uds_fetch_if.sv
// rtl/uds_fetch_if.sv - UDS core bus port and word stream bundle for uds_fetch
interface uds_fetch_if;
  logic        bus_cs;
  logic [7:0]  bus_address;
  logic [31:0] bus_read_data;
  logic        bus_ready;
  logic [31:0] word_data;
  logic [2:0]  word_index;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output bus_cs, bus_address, word_data, word_index, word_valid,
    input  bus_read_data, bus_ready, word_ready
  );

  modport slave (
    input  bus_cs, bus_address, word_data, word_index, word_valid,
    output bus_read_data, bus_ready, word_ready
  );
endinterface

// File: rtl/uds_fetch.sv
// rtl/uds_fetch.sv - checks UDS core ID then reads each UDS word once onto a valid/ready stream
module uds_fetch #(
  parameter logic [31:0] EXP_NAME0      = 32'h7564735f,
  parameter logic [31:0] EXP_NAME1      = 32'h6d656d20,
  parameter logic [31:0] EXP_VERSION    = 32'h00000001,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  uds_fetch_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_RD, S_UDS_RD, S_UDS_OUT, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] to_q, to_d;
  logic          nonzero_q, nonzero_d;
  logic [31:0]   word_data_q, word_data_d;
  logic [2:0]    word_index_q, word_index_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [TW-1:0] to_inc;
  logic [31:0]   exp_id;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      to_q         <= '0;
      nonzero_q    <= 1'b0;
      word_data_q  <= '0;
      word_index_q <= '0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      to_q         <= to_d;
      nonzero_q    <= nonzero_d;
      word_data_q  <= word_data_d;
      word_index_q <= word_index_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    to_d            = to_q;
    nonzero_d       = nonzero_q;
    word_data_d     = word_data_q;
    word_index_d    = word_index_q;
    err_code_d      = err_code_q;
    busy            = 1'b0;
    done            = 1'b0;
    bus.bus_cs      = 1'b0;
    bus.bus_address = '0;
    bus.word_valid  = 1'b0;
    to_inc          = (to_q == TO_LIMIT) ? to_q : to_q + 1'b1;
    case (idx_q)
      3'd0:    exp_id = EXP_NAME0;
      3'd1:    exp_id = EXP_NAME1;
      default: exp_id = EXP_VERSION;
    endcase

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        done = (state_q == S_DONE);
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          state_d    = S_ID_RD;
          idx_d      = '0;
          to_d       = '0;
          nonzero_d  = 1'b0;
          err_code_d = 2'b00;
        end
      end
      S_ID_RD: begin
        busy            = 1'b1;
        bus.bus_cs      = 1'b1;
        bus.bus_address = {5'd0, idx_q};
        if (bus.bus_ready) begin
          to_d = '0;
          if (bus.bus_read_data != exp_id) begin
            state_d    = S_ERR;
            err_code_d = 2'b01;
          end else if (idx_q == 3'd2) begin
            idx_d   = '0;
            state_d = S_UDS_RD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          to_d = to_inc;
          if (to_inc == TO_LIMIT) begin
            state_d    = S_ERR;
            err_code_d = 2'b10;
          end
        end
      end
      S_UDS_RD: begin
        // Each UDS address is read-once in the core, so leave this state on the first completion.
        busy            = 1'b1;
        bus.bus_cs      = 1'b1;
        bus.bus_address = {5'b00010, idx_q};
        if (bus.bus_ready) begin
          to_d         = '0;
          word_data_d  = bus.bus_read_data;
          word_index_d = idx_q;
          nonzero_d    = nonzero_q | (|bus.bus_read_data);
          state_d      = S_UDS_OUT;
        end else begin
          to_d = to_inc;
          if (to_inc == TO_LIMIT) begin
            state_d    = S_ERR;
            err_code_d = 2'b10;
          end
        end
      end
      S_UDS_OUT: begin
        busy           = 1'b1;
        bus.word_valid = 1'b1;
        if (bus.word_ready) begin
          if (idx_q != 3'd7) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_UDS_RD;
          end else if (!nonzero_q) begin
            state_d    = S_ERR;
            err_code_d = 2'b11;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign error          = (state_q == S_ERR);
  assign err_code       = err_code_q;
  assign bus.word_data  = word_data_q;
  assign bus.word_index = word_index_q;
endmodule

// File: tb/tb_uds_fetch.sv
// tb/tb_uds_fetch.sv - vector table, randomized runs against a fetch model, and reset corner case
module tb_uds_fetch;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [1:0] err_code;

  uds_fetch_if bus_if();

  uds_fetch dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ID0 = 32'h7564735f;
  localparam logic [31:0] ID1 = 32'h6d656d20;
  localparam logic [31:0] ID2 = 32'h00000001;

  logic [31:0] mem [256];
  logic [7:0]  stuck_addr = 8'hFF;
  bit          ready_en = 1'b1;
  bit          wr_en = 1'b1;
  bit          rand_mode = 1'b0;
  int          stall_word = -1;
  int          stall_used = 0;

  assign bus_if.bus_read_data = mem[bus_if.bus_address];
  assign bus_if.bus_ready     = bus_if.bus_cs && ready_en && (bus_if.bus_address != stuck_addr);
  assign bus_if.word_ready    = wr_en;

  int          acc_cnt [256];
  int          exp_acc [256];
  int          stall_run = 0;
  int          done_cnt = 0;
  int          stab_err = 0;
  logic [31:0] got_data [$];
  int          got_idx [$];
  bit          hold = 1'b0;
  logic [31:0] hold_d;
  logic [2:0]  hold_i;

  int errors = 0;
  int checks = 0;

  // Monitor: samples mid-cycle, so a handshake seen here completes at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.bus_cs && bus_if.bus_ready) acc_cnt[bus_if.bus_address]++;
      stall_run = (bus_if.bus_cs && !bus_if.bus_ready) ? stall_run + 1 : 0;
      if (done) done_cnt++;
      if (bus_if.word_valid && bus_if.bus_cs) stab_err++;
      if (hold && (!bus_if.word_valid || bus_if.word_data !== hold_d || bus_if.word_index !== hold_i))
        stab_err++;
      if (bus_if.word_valid && bus_if.word_ready) begin
        got_data.push_back(bus_if.word_data);
        got_idx.push_back(int'(bus_if.word_index));
      end
      hold   = bus_if.word_valid && !bus_if.word_ready;
      hold_d = bus_if.word_data;
      hold_i = bus_if.word_index;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        ready_en = (stall_run >= 5) || ($urandom_range(0, 3) != 0);
        wr_en    = ($urandom_range(0, 2) != 0);
      end else begin
        ready_en = 1'b1;
        wr_en    = 1'b1;
      end
      if (!busy) stall_used = 0;
      else if (bus_if.word_valid && int'(bus_if.word_index) == stall_word && stall_used < 5) begin
        wr_en = 1'b0;
        stall_used++;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: walk the fetch as the ID-check/read-once rules describe it.
  task automatic model(input logic [7:0] stk, output logic [1:0] code, output bit dn, output int nw);
    logic [31:0] ids [3];
    logic [31:0] acc;
    ids  = '{ID0, ID1, ID2};
    code = 2'b00;
    dn   = 1'b0;
    nw   = 0;
    acc  = '0;
    for (int a = 0; a < 256; a++) exp_acc[a] = 0;
    for (int i = 0; i < 3; i++) begin
      if (int'(stk) == i) begin code = 2'b10; return; end
      exp_acc[i] = 1;
      if (mem[i] !== ids[i]) begin code = 2'b01; return; end
    end
    for (int k = 0; k < 8; k++) begin
      if (int'(stk) == 16 + k) begin code = 2'b10; return; end
      exp_acc[16 + k] = 1;
      nw++;
      acc |= mem[16 + k];
    end
    if (acc == 0) code = 2'b11;
    else dn = 1'b1;
  endtask

  task automatic run_one(input string nm, input logic [1:0] e_code, input bit e_dn, input int e_nw,
                         input int t_exp, input int restart, input int budget);
    int b_acc [256];
    int b_words, b_done, b_stab, t_end, bad, got_n;
    logic [1:0] m_code;
    bit m_dn;
    int m_nw;
    bit busy1;
    model(stuck_addr, m_code, m_dn, m_nw);
    for (int a = 0; a < 256; a++) b_acc[a] = acc_cnt[a];
    b_words = got_data.size();
    b_done  = done_cnt;
    b_stab  = stab_err;
    busy1   = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    t_end = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = busy;
      start = (n == restart);
      if (done || error) begin t_end = n; break; end
    end
    start = 1'b0;
    chk({nm, " finished"}, (t_end != -1), 1);
    if (t_exp >= 0) begin
      chk({nm, " end cycle"}, t_end, t_exp);
      chk({nm, " busy at T1"}, busy1, 1);
    end
    chk({nm, " err_code"}, err_code, e_code);
    chk({nm, " error"}, error, (e_code != 2'b00));
    chk({nm, " quiet at end"}, {busy, bus_if.bus_cs, bus_if.word_valid}, 0);
    @(negedge clk);
    chk({nm, " done pulses"}, done_cnt - b_done, e_dn);
    got_n = got_data.size() - b_words;
    chk({nm, " word count"}, got_n, e_nw);
    bad = 0;
    for (int k = 0; k < got_n && k < m_nw; k++)
      if (got_data[b_words + k] !== mem[16 + k] || got_idx[b_words + k] != k) bad++;
    chk({nm, " word content"}, bad, 0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (acc_cnt[a] - b_acc[a] != exp_acc[a]) bad++;
    chk({nm, " access map"}, bad, 0);
    chk({nm, " stream stability"}, stab_err - b_stab, 0);
  endtask

  typedef struct {
    logic [31:0] id1;
    bit          zw;
    logic [7:0]  stuck;
    int          restart;
    int          stall_w;
    logic [1:0]  code;
    bit          dn;
    int          nw;
    int          t_end;
  } vec_t;

  vec_t tbl [7];

  task automatic load_mem(input logic [31:0] id1, input bit zw);
    for (int a = 0; a < 256; a++) mem[a] = 32'hDEAD0000 | a;
    mem[0] = ID0;
    mem[1] = id1;
    mem[2] = ID2;
    for (int k = 0; k < 8; k++) mem[16 + k] = zw ? 32'h0 : 32'h11111111 * (k + 1);
  endtask

  initial begin
    logic [1:0] m_code;
    bit m_dn;
    int m_nw, s, found, dc;

    tbl[0] = '{ID1,   1'b0, 8'hFF, 0, -1, 2'b00, 1'b1, 8, 20};
    tbl[1] = '{ID1,   1'b1, 8'hFF, 0, -1, 2'b11, 1'b0, 8, 20};
    tbl[2] = '{32'h0, 1'b0, 8'hFF, 0, -1, 2'b01, 1'b0, 0, 3};
    tbl[3] = '{ID1,   1'b0, 8'h12, 0, -1, 2'b10, 1'b0, 2, 24};
    tbl[4] = '{ID1,   1'b0, 8'h00, 0, -1, 2'b10, 1'b0, 0, 17};
    tbl[5] = '{ID1,   1'b0, 8'hFF, 6, -1, 2'b00, 1'b1, 8, 20};
    tbl[6] = '{ID1,   1'b0, 8'hFF, 0,  3, 2'b00, 1'b1, 8, 25};

    load_mem(ID1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {busy, done, error, err_code, bus_if.bus_cs, bus_if.bus_address,
                          bus_if.word_valid, bus_if.word_data, bus_if.word_index}, 0);
    @(posedge clk); #1; reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      load_mem(tbl[i].id1, tbl[i].zw);
      stuck_addr = tbl[i].stuck;
      stall_word = tbl[i].stall_w;
      run_one($sformatf("vec%0d", i), tbl[i].code, tbl[i].dn, tbl[i].nw,
              tbl[i].t_end, tbl[i].restart, 200);
    end
    stall_word = -1;

    rand_mode = 1'b1;
    for (int it = 0; it < 30; it++) begin
      load_mem(ID1, 1'b0);
      if ($urandom_range(0, 4) == 0) mem[$urandom_range(0, 2)] ^= 32'h1 << $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) for (int k = 0; k < 8; k++) mem[16 + k] = 32'h0;
      else for (int k = 0; k < 8; k++) mem[16 + k] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      stuck_addr = 8'hFF;
      if ($urandom_range(0, 5) == 0) begin
        s = $urandom_range(0, 10);
        stuck_addr = (s < 3) ? 8'(s) : 8'(16 + s - 3);
      end
      model(stuck_addr, m_code, m_dn, m_nw);
      run_one($sformatf("rand%0d", it), m_code, m_dn, m_nw, -1, 0, 800);
    end
    rand_mode  = 1'b0;
    stuck_addr = 8'hFF;

    load_mem(ID1, 1'b0);
    dc = done_cnt;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus_if.word_valid && bus_if.word_index == 3'd4) begin found = 1; break; end
    end
    chk("reach word4", found, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid reset outputs", {busy, done, error, err_code, bus_if.bus_cs, bus_if.bus_address,
                              bus_if.word_valid, bus_if.word_data, bus_if.word_index}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle after reset", {busy, bus_if.bus_cs, bus_if.word_valid, error}, 0);
    chk("no done after reset", done_cnt - dc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
